fir_sym_sequencer: RTL and testbench
====================================

// Module: fir_sym_sequencer
// PURPOSE
//  Serial controller for a time-shared symmetric-FIR multiply element.
//  Accepts input samples over a valid/ready handshake and stores them in a circular delay line.
//  For each sample, issues one pre-add/multiply request per coefficient pair: tap samples A and B plus coef.
//  Accumulates the returned products and presents one filter output per input sample.
//  Sits upstream and downstream of the multiply element; holds the coefficient RAM.
// PARAMETERS
//  DATA_BITS   16   sample width, signed two's complement
//  COEF_BITS   16   coefficient width, signed
//  TAPS        16   filter length N, >=2, odd or even
//  EXTEND_BITS 5    guard bits on products and accumulator
//  OUT_BITS    DATA_BITS+COEF_BITS+EXTEND_BITS   product/accumulator/output width
//  PAIRS       (TAPS+1)/2 (derived, localparam)   coefficient count = issue cycles per sample
// PORTS
//  clk        in   1                  clock, rising edge
//  rst        in   1                  reset, asynchronous, active-high
//  s_valid    in   1                  input sample valid
//  s_ready    out  1                  input sample ready
//  s_data     in   DATA_BITS          input sample
//  coef_we    in   1                  coefficient write strobe
//  coef_addr  in   $clog2(PAIRS)      coefficient index p
//  coef_wdata in   COEF_BITS          coefficient value c[p]
//  mac_en     out  1                  multiply request
//  mac_a      out  DATA_BITS          tap sample A
//  mac_b      out  DATA_BITS          tap sample B
//  mac_coef   out  COEF_BITS          coefficient for the pair
//  mac_prod   in   OUT_BITS           sign-extended (A+B)*coef, 1-cycle latency
//  mac_vld    in   1                  mac_prod valid
//  m_valid    out  1                  filter output valid
//  m_ready    in   1                  filter output accepted
//  m_data     out  OUT_BITS           filter output y[n]
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; delay line, coefficient RAM, accumulator, counters = 0.
//   - Outputs: s_ready=1, m_valid=0, m_data=0, mac_en=0, mac_a=mac_b=mac_coef=0.
//   - Reset mid-operation aborts the current sample; no partial output is produced.
//  FSM:
//   - IDLE: s_ready=1. On s_valid: write s_data at wr_ptr; advance wr_ptr mod TAPS; clear acc, issue and return counters; go to ISSUE.
//   - ISSUE: s_ready=0. Lasts exactly PAIRS cycles, p=0..PAIRS-1; mac_en=1.
//       mac_a=x[n-p], mac_b=x[n-(TAPS-1-p)], mac_coef=c[p]; x[n] is the newest sample.
//       Odd TAPS, p=PAIRS-1 (centre tap): mac_b=0, so the centre tap counts once.
//       After p=PAIRS-1, go to DRAIN.
//   - DRAIN: mac_en=0; mac_a/mac_b/mac_coef=0. Wait until returned-product count == PAIRS, then go to OUT.
//   - OUT: m_valid=1, m_data=acc. Hold both stable until m_valid&&m_ready, then go to IDLE.
//  Datapath rules:
//   - mac_* outputs are combinational from the state, p and RAM reads.
//   - acc += mac_prod on every cycle where mac_vld=1 and state is ISSUE or DRAIN.
//   - Accumulation is OUT_BITS two's-complement and wraps; no saturation.
//   - mac_vld in IDLE or OUT is ignored.
//  Latency (mac 1-cycle, m_ready=1):
//   - Sample accepted at edge E0; ISSUE spans cycles 1..PAIRS after E0; last product is valid in cycle PAIRS+1.
//   - m_valid=1 in cycle PAIRS+2. TAPS=16 gives cycle 10.
//   - Handshake in OUT returns to IDLE; next sample can be accepted one cycle later. Throughput is 1 sample per PAIRS+3 cycles.
//  Coefficients:
//   - Writes are honoured only in IDLE and OUT; ignored in ISSUE and DRAIN.
//   - coef_addr >= PAIRS is ignored.
//   - A write takes effect for the next accepted sample.
//  Delay line:
//   - Zero after reset. The first TAPS-1 outputs see zeros in older taps.
//   - Wrap of wr_ptr from TAPS-1 to 0 is seamless.
// TESTING
//  1 TAPS=16, c[p]=p+1, impulse 1 then 0s -> y=1,2,..,8,8,7,..,1, then 0.
//  2 TAPS=5, c=[1,2,3], impulse 5 -> y=5,10,15,10,5,0 (centre tap counted once).
//  3 TAPS=16, all c=1, constant 100 -> from sample 16 onward, y=1600.
//  4 TAPS=16, all c=32767, constant -32768 -> steady y=-17179344896; no wrap at OUT_BITS=37.
//  5 m_ready=0 for 10 cycles in OUT -> m_valid/m_data stable; s_ready=0; s_valid sample held off and accepted after the handshake.
//  6 rst pulse in ISSUE cycle p=3 -> all outputs 0 and s_ready=1 immediately.
//    Next impulse after a fresh coefficient load reproduces scenario 1 exactly.

Source files
------------

// File: rtl/fir_sym_sequencer.sv
// rtl/fir_sym_sequencer.sv - sequencer for a time-shared symmetric-FIR pre-add/multiply element
// Holds the delay line and coefficient RAM, issues one tap pair per cycle, accumulates products.
module fir_sym_sequencer #(
  parameter int DATA_BITS   = 16,
  parameter int COEF_BITS   = 16,
  parameter int TAPS        = 16,
  parameter int EXTEND_BITS = 5,
  parameter int OUT_BITS    = DATA_BITS + COEF_BITS + EXTEND_BITS,
  localparam int PAIRS      = (TAPS + 1) / 2,
  localparam int CA_BITS    = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 coef_we,
  input  logic [CA_BITS-1:0]   coef_addr,
  input  logic [COEF_BITS-1:0] coef_wdata,
  output logic                 mac_en,
  output logic [DATA_BITS-1:0] mac_a,
  output logic [DATA_BITS-1:0] mac_b,
  output logic [COEF_BITS-1:0] mac_coef,
  input  logic [OUT_BITS-1:0]  mac_prod,
  input  logic                 mac_vld,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_BITS-1:0]  m_data
);

  localparam int PTR_BITS = $clog2(TAPS);
  localparam int CNT_BITS = $clog2(PAIRS + 1);
  localparam bit ODD      = (TAPS % 2) == 1;

  localparam logic [PTR_BITS:0]   TAPS_W   = (PTR_BITS + 1)'(TAPS);
  localparam logic [PTR_BITS:0]   ONE_W    = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(TAPS - 1);
  localparam logic [CNT_BITS-1:0] LAST_P   = CNT_BITS'(PAIRS - 1);
  localparam logic [CNT_BITS-1:0] PAIRS_C  = CNT_BITS'(PAIRS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] dline [0:TAPS-1];
  logic [COEF_BITS-1:0] coef  [0:PAIRS-1];
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  newest;
  logic [CNT_BITS-1:0]  p_cnt;
  logic [CNT_BITS-1:0]  ret_cnt;
  logic [OUT_BITS-1:0]  acc;

  logic                 take_prod;
  logic [OUT_BITS-1:0]  acc_next;
  logic [CNT_BITS-1:0]  ret_next;
  logic [PTR_BITS:0]    p_ext;
  logic [PTR_BITS:0]    a_sum;
  logic [PTR_BITS:0]    b_sum;
  logic [PTR_BITS-1:0]  a_idx;
  logic [PTR_BITS-1:0]  b_idx;

  // Products are only meaningful while a sample is in flight.
  always_comb begin
    take_prod = mac_vld && (state == ISSUE || state == DRAIN);
    acc_next  = acc;
    ret_next  = ret_cnt;
    if (take_prod) begin
      acc_next = acc + mac_prod;
      ret_next = ret_cnt + CNT_BITS'(1);
    end
  end

  // x[n-p] sits p slots behind newest; x[n-(TAPS-1-p)] sits p+1 slots ahead of it.
  always_comb begin
    p_ext = (PTR_BITS + 1)'(p_cnt);
    a_sum = {1'b0, newest} + TAPS_W - p_ext;
    if (a_sum >= TAPS_W) a_sum = a_sum - TAPS_W;
    b_sum = {1'b0, newest} + p_ext + ONE_W;
    if (b_sum >= TAPS_W) b_sum = b_sum - TAPS_W;
    a_idx = a_sum[PTR_BITS-1:0];
    b_idx = b_sum[PTR_BITS-1:0];
  end

  always_comb begin
    mac_en   = 1'b0;
    mac_a    = '0;
    mac_b    = '0;
    mac_coef = '0;
    if (state == ISSUE) begin
      mac_en   = 1'b1;
      mac_a    = dline[a_idx];
      mac_coef = coef[p_cnt[CA_BITS-1:0]];
      if (!(ODD && p_cnt == LAST_P)) mac_b = dline[b_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      wr_ptr  <= '0;
      newest  <= '0;
      p_cnt   <= '0;
      ret_cnt <= '0;
      acc     <= '0;
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
      for (int i = 0; i < PAIRS; i++) coef[i] <= '0;
    end else begin
      // Out-of-range addresses match no entry and are dropped.
      if (coef_we && (state == IDLE || state == OUT)) begin
        for (int i = 0; i < PAIRS; i++)
          if (coef_addr == CA_BITS'(i)) coef[i] <= coef_wdata;
      end

      case (state)
        IDLE: begin
          if (s_valid) begin
            dline[wr_ptr] <= s_data;
            newest        <= wr_ptr;
            wr_ptr        <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_BITS'(1);
            acc           <= '0;
            p_cnt         <= '0;
            ret_cnt       <= '0;
            s_ready       <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          acc     <= acc_next;
          ret_cnt <= ret_next;
          if (p_cnt == LAST_P) state <= DRAIN;
          else                 p_cnt <= p_cnt + CNT_BITS'(1);
        end
        DRAIN: begin
          acc     <= acc_next;
          ret_cnt <= ret_next;
          if (ret_next >= PAIRS_C) begin
            m_valid <= 1'b1;
            m_data  <= acc_next;
            state   <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sym_sequencer.sv
// tb/tb_fir_sym_sequencer.sv - directed bench for fir_sym_sequencer (TAPS=16 and TAPS=5)
module tb_fir_sym_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  // TAPS=16 instance
  logic        s_valid16, s_ready16, coef_we16, mac_en16, mac_vld16, m_valid16, m_ready16;
  logic [15:0] s_data16, coef_wdata16, mac_a16, mac_b16, mac_coef16;
  logic [2:0]  coef_addr16;
  logic [36:0] mac_prod16, m_data16;

  // TAPS=5 instance
  logic        s_valid5, s_ready5, coef_we5, mac_en5, mac_vld5, m_valid5, m_ready5;
  logic [15:0] s_data5, coef_wdata5, mac_a5, mac_b5, mac_coef5;
  logic [1:0]  coef_addr5;
  logic [36:0] mac_prod5, m_data5;

  fir_sym_sequencer #(.TAPS(16)) dut16 (
    .clk(clk), .rst(rst), .s_valid(s_valid16), .s_ready(s_ready16), .s_data(s_data16),
    .coef_we(coef_we16), .coef_addr(coef_addr16), .coef_wdata(coef_wdata16),
    .mac_en(mac_en16), .mac_a(mac_a16), .mac_b(mac_b16), .mac_coef(mac_coef16),
    .mac_prod(mac_prod16), .mac_vld(mac_vld16),
    .m_valid(m_valid16), .m_ready(m_ready16), .m_data(m_data16)
  );

  fir_sym_sequencer #(.TAPS(5)) dut5 (
    .clk(clk), .rst(rst), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .coef_we(coef_we5), .coef_addr(coef_addr5), .coef_wdata(coef_wdata5),
    .mac_en(mac_en5), .mac_a(mac_a5), .mac_b(mac_b5), .mac_coef(mac_coef5),
    .mac_prod(mac_prod5), .mac_vld(mac_vld5),
    .m_valid(m_valid5), .m_ready(m_ready5), .m_data(m_data5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
    longint t;
    t = (longint'($signed(a)) + longint'($signed(b))) * longint'($signed(c));
    return t[36:0];
  endfunction

  // Multiply element with one cycle of latency.
  always_ff @(posedge clk) begin
    mac_vld16  <= mac_en16;
    mac_prod16 <= mac_fn(mac_a16, mac_b16, mac_coef16);
    mac_vld5   <= mac_en5;
    mac_prod5  <= mac_fn(mac_a5, mac_b5, mac_coef5);
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load16(input int addr, input int val);
    coef_we16 = 1'b1; coef_addr16 = 3'(addr); coef_wdata16 = 16'(val);
    @(negedge clk);
    coef_we16 = 1'b0;
  endtask

  task automatic load5(input int addr, input int val);
    coef_we5 = 1'b1; coef_addr5 = 2'(addr); coef_wdata5 = 16'(val);
    @(negedge clk);
    coef_we5 = 1'b0;
  endtask

  // Entered at the negedge of cycle 1 after acceptance; leaves in the OUT cycle.
  task automatic recv16(input string tag, input longint exp);
    int lat;
    lat = 1;
    while (!m_valid16 && lat < 100) begin @(negedge clk); lat++; end
    check_eq({tag, "_lat"}, lat, 10);
    check_eq(tag, longint'($signed(m_data16)), exp);
  endtask

  task automatic send16(input string tag, input int x, input longint exp);
    int n;
    n = 0;
    while (!s_ready16 && n < 100) begin @(negedge clk); n++; end
    s_valid16 = 1'b1; s_data16 = 16'(x);
    @(negedge clk);
    s_valid16 = 1'b0;
    recv16(tag, exp);
    @(negedge clk);
  endtask

  task automatic send5(input string tag, input int x, input longint exp);
    int lat;
    s_valid5 = 1'b1; s_data5 = 16'(x);
    @(negedge clk);
    s_valid5 = 1'b0;
    lat = 1;
    while (!m_valid5 && lat < 100) begin @(negedge clk); lat++; end
    check_eq({tag, "_lat"}, lat, 5);
    check_eq(tag, longint'($signed(m_data5)), exp);
    @(negedge clk);
  endtask

  task automatic impulse_run(input string tag);
    for (int p = 0; p < 8; p++) load16(p, p + 1);
    for (int k = 0; k <= 16; k++)
      send16($sformatf("%s_y%0d", tag, k), (k == 0) ? 1 : 0, (k == 16) ? 0 : ((k < 8) ? k + 1 : 16 - k));
  endtask

  initial begin
    int seen;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    s_valid16 = 0; s_data16 = 0; coef_we16 = 0; coef_addr16 = 0; coef_wdata16 = 0; m_ready16 = 1;
    s_valid5 = 0;  s_data5 = 0;  coef_we5 = 0;  coef_addr5 = 0;  coef_wdata5 = 0;  m_ready5 = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_s_ready", s_ready16, 1);
    check_eq("rst_m_valid", m_valid16, 0);
    check_eq("rst_m_data", m_data16, 0);
    check_eq("rst_mac_en", mac_en16, 0);
    check_eq("rst_mac_a", mac_a16, 0);
    check_eq("rst_mac_b", mac_b16, 0);
    check_eq("rst_mac_coef", mac_coef16, 0);

    // TAPS=5, centre tap counted once; address 3 is out of range.
    load5(0, 1); load5(1, 2); load5(2, 3); load5(3, 77);
    send5("t5_y0", 5, 5);
    send5("t5_y1", 0, 10);
    send5("t5_y2", 0, 15);
    send5("t5_y3", 0, 10);
    send5("t5_y4", 0, 5);
    send5("t5_y5", 0, 0);

    impulse_run("imp");

    for (int p = 0; p < 8; p++) load16(p, 1);
    for (int k = 1; k <= 17; k++)
      send16($sformatf("const_y%0d", k), 100, (k <= 16) ? 100 * k : 1600);

    // Writes during ISSUE and DRAIN must be dropped.
    fork
      send16("issue_wr_y", 100, 1600);
      begin
        @(negedge clk);
        coef_we16 = 1'b1; coef_addr16 = 3'd0; coef_wdata16 = 16'd5;
        repeat (9) @(negedge clk);
        coef_we16 = 1'b0;
      end
    join
    send16("issue_wr_next", 100, 1600);

    // Output back-pressure; a write in OUT applies to the held-off sample.
    m_ready16 = 1'b0;
    s_valid16 = 1'b1; s_data16 = 16'd100;
    @(negedge clk);
    s_valid16 = 1'b0;
    recv16("hold_y", 1600);
    s_valid16 = 1'b1; s_data16 = 16'd100;
    coef_we16 = 1'b1; coef_addr16 = 3'd0; coef_wdata16 = 16'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      coef_we16 = 1'b0;
      check_eq($sformatf("hold_m_valid%0d", i), m_valid16, 1);
      check_eq($sformatf("hold_m_data%0d", i), longint'($signed(m_data16)), 1600);
      check_eq($sformatf("hold_s_ready%0d", i), s_ready16, 0);
    end
    m_ready16 = 1'b1;
    @(negedge clk);
    check_eq("hs_m_valid", m_valid16, 0);
    check_eq("hs_s_ready", s_ready16, 1);
    @(negedge clk);
    s_valid16 = 1'b0;
    recv16("held_sample_y", 1800);
    @(negedge clk);

    // Full-scale inputs: 8 * (-65536 * 32767) fits in 37 bits.
    for (int p = 0; p < 8; p++) load16(p, 32767);
    for (int k = 1; k <= 15; k++) begin
      s_valid16 = 1'b1; s_data16 = 16'h8000;
      @(negedge clk);
      s_valid16 = 1'b0;
      repeat (11) @(negedge clk);
    end
    send16("full_y16", -32768, -64'sd17179344896);
    send16("full_y17", -32768, -64'sd17179344896);

    // Reset while issuing pair 3.
    s_valid16 = 1'b1; s_data16 = 16'd1;
    @(negedge clk);
    s_valid16 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_coef", mac_coef16, 32767);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_s_ready", s_ready16, 1);
    check_eq("mid_rst_m_valid", m_valid16, 0);
    check_eq("mid_rst_m_data", m_data16, 0);
    check_eq("mid_rst_mac_en", mac_en16, 0);
    check_eq("mid_rst_mac_coef", mac_coef16, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (m_valid16) seen++;
    end
    check_eq("no_partial_out", seen, 0);

    impulse_run("imp2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
